// File: rtl/axi_ecc_pkg.sv
// axi_ecc_pkg: shared response codes, FSM/status types and SECDED helpers
package axi_ecc_pkg;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, RD_PIPE, RD_RESP, RMW_RD, WR_RESP} axi_state_e;
    typedef enum logic [1:0] {NONE, CORR, UNCORR} ecc_status_e;

    function automatic int chk_w(input int data_w);
        return $clog2(data_w) + 2;
    endfunction

    // Hamming position of data bit i: the i-th integer >= 3 that is not a power of two
    function automatic int hpos(input int i);
        int n = 2;
        int k = -1;
        while (k < i) begin
            n++;
            if ((n & (n - 1)) != 0) k++;
        end
        return n;
    endfunction
endpackage

// File: rtl/ecc_secded_codec.sv
// ecc_secded_codec: combinational SECDED encode/decode, codeword = {overall parity, hamming bits, data}
module ecc_secded_codec
    import axi_ecc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CHK_W  = chk_w(DATA_W)
) (
    input  logic [DATA_W-1:0]       enc_data,
    output logic [DATA_W+CHK_W-1:0] enc_cw,
    input  logic [DATA_W+CHK_W-1:0] dec_cw,
    output logic [DATA_W-1:0]       dec_data,
    output ecc_status_e             dec_status,
    output logic [CHK_W-2:0]        dec_syn
);
    localparam int HW = CHK_W - 1;

    function automatic logic [HW*DATA_W-1:0] hmask_f();
        logic [HW*DATA_W-1:0] m = '0;
        for (int i = 0; i < DATA_W; i++)
            for (int j = 0; j < HW; j++)
                m[j*DATA_W+i] = ((hpos(i) >> j) & 1) != 0;
        return m;
    endfunction

    localparam logic [HW*DATA_W-1:0] HM = hmask_f();

    function automatic logic [HW-1:0] ham(input logic [DATA_W-1:0] d);
        logic [HW-1:0] h;
        for (int j = 0; j < HW; j++) h[j] = ^(d & HM[j*DATA_W +: DATA_W]);
        return h;
    endfunction

    logic [HW-1:0]     enc_h;
    logic [DATA_W-1:0] d, flip;
    logic              par, hit;

    assign enc_h  = ham(enc_data);
    assign enc_cw = {^{enc_h, enc_data}, enc_h, enc_data};

    assign d       = dec_cw[DATA_W-1:0];
    assign dec_syn = dec_cw[DATA_W+HW-1:DATA_W] ^ ham(d);
    assign par     = ^dec_cw;

    for (genvar i = 0; i < DATA_W; i++) begin : g_flip
        assign flip[i] = dec_syn == HW'(hpos(i));
    end

    // odd parity with a zero, one-hot or data-position syndrome is a single flip; anything else is fatal
    assign hit        = dec_syn == '0 || $onehot(dec_syn) || |flip;
    assign dec_data   = par ? d ^ flip : d;
    assign dec_status = !par && dec_syn == '0 ? NONE : par && hit ? CORR : UNCORR;
endmodule

// File: rtl/axi_ecc_memory.sv
// axi_ecc_memory: AXI4-lite SECDED RAM with error injection, scrubbing, RMW byte writes and error counters
module axi_ecc_memory
    import axi_ecc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32768,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16,
    parameter bit SCRUB  = 1,
    parameter int CHK_W  = chk_w(DATA_W)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_axi_awvalid,
    output logic                    mem_axi_awready,
    input  logic [31:0]             mem_axi_awaddr,
    input  logic                    mem_axi_wvalid,
    output logic                    mem_axi_wready,
    input  logic [DATA_W-1:0]       mem_axi_wdata,
    input  logic [DATA_W/8-1:0]     mem_axi_wstrb,
    output logic                    mem_axi_bvalid,
    input  logic                    mem_axi_bready,
    output logic [1:0]              mem_axi_bresp,
    input  logic                    mem_axi_arvalid,
    output logic                    mem_axi_arready,
    input  logic [31:0]             mem_axi_araddr,
    output logic                    mem_axi_rvalid,
    input  logic                    mem_axi_rready,
    output logic [DATA_W-1:0]       mem_axi_rdata,
    output logic [1:0]              mem_axi_rresp,
    input  logic [DATA_W+CHK_W-1:0] inj_mask,
    output logic                    err_corr,
    output logic                    err_uncorr,
    output logic [CNT_W-1:0]        corr_cnt,
    output logic [CNT_W-1:0]        uncorr_cnt,
    input  logic                    cnt_clr
);
    localparam int          CW        = DATA_W + CHK_W;
    localparam int          NB        = DATA_W / 8;
    localparam int          OB        = $clog2(NB);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          LW        = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
    localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'(NB);

    logic [CW-1:0]     mem [DEPTH];
    axi_state_e        state, state_n;
    logic [CW-1:0]     cw_q, wr_cw, fix_cw;
    logic [AW-1:0]     idx_q, ar_idx, aw_idx;
    logic [DATA_W-1:0] wdata_q, merged, dec_data, wr_unused_data;
    logic [NB-1:0]     wstrb_q;
    logic [LW-1:0]     lat_q;
    logic [CHK_W-2:0]  rd_syn_unused, wr_syn_unused;
    ecc_status_e       dec_status, wr_status_unused;
    logic oor_q, ar_oor, aw_oor, rr_wr, scrub_q, grant_rd, grant_wr, conflict;
    logic rd_done, bad, corr_ev, uncorr_ev, mem_we;

    assign ar_idx = mem_axi_araddr[OB +: AW];
    assign aw_idx = mem_axi_awaddr[OB +: AW];
    assign ar_oor = {32'd0, mem_axi_araddr} >= MEM_BYTES;
    assign aw_oor = {32'd0, mem_axi_awaddr} >= MEM_BYTES;

    // rr_wr set means the next read/write conflict is won by the write
    assign conflict = state == IDLE && !reset && mem_axi_arvalid && mem_axi_awvalid && mem_axi_wvalid;
    assign grant_rd = state == IDLE && !reset && mem_axi_arvalid && !(conflict && rr_wr);
    assign grant_wr = state == IDLE && !reset && mem_axi_awvalid && mem_axi_wvalid && !grant_rd;

    assign mem_axi_arready = grant_rd;
    assign mem_axi_awready = grant_wr;
    assign mem_axi_wready  = grant_wr;
    assign mem_axi_rvalid  = state == RD_RESP;
    assign mem_axi_bvalid  = state == WR_RESP;

    assign rd_done   = state == RD_PIPE && lat_q == LW'(RD_LAT - 1);
    assign bad       = oor_q || dec_status == UNCORR;
    assign corr_ev   = !oor_q && dec_status == CORR && (rd_done || state == RMW_RD);
    assign uncorr_ev = !oor_q && dec_status == UNCORR && (rd_done || state == RMW_RD);
    assign mem_we    = (grant_wr && &mem_axi_wstrb && !aw_oor) ||
                       (state == RMW_RD && !bad) || (state == RD_RESP && scrub_q);

    always_comb begin
        merged = dec_data;
        for (int b = 0; b < NB; b++) if (wstrb_q[b]) merged[b*8 +: 8] = wdata_q[b*8 +: 8];
    end

    ecc_secded_codec #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_wr_codec (
        .enc_data(mem_axi_wdata), .enc_cw(wr_cw), .dec_cw('0),
        .dec_data(wr_unused_data), .dec_status(wr_status_unused), .dec_syn(wr_syn_unused)
    );

    ecc_secded_codec #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_rd_codec (
        .enc_data(state == RD_RESP ? mem_axi_rdata : merged), .enc_cw(fix_cw), .dec_cw(cw_q),
        .dec_data(dec_data), .dec_status(dec_status), .dec_syn(rd_syn_unused)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = grant_rd ? RD_PIPE : !grant_wr ? IDLE :
                               (&mem_axi_wstrb || ~|mem_axi_wstrb) ? WR_RESP : RMW_RD;
            RD_PIPE: state_n = rd_done ? RD_RESP : RD_PIPE;
            RD_RESP: state_n = mem_axi_rready ? IDLE : RD_RESP;
            RMW_RD:  state_n = WR_RESP;
            WR_RESP: state_n = mem_axi_bready ? IDLE : WR_RESP;
            default: state_n = IDLE;
        endcase
    end

    // the injection mask only ever affects the captured copy, never the array
    always_ff @(posedge clk) begin
        if (mem_we) mem[grant_wr ? aw_idx : idx_q] <= grant_wr ? wr_cw : fix_cw;
        if (grant_rd || grant_wr) begin
            cw_q  <= mem[grant_rd ? ar_idx : aw_idx] ^ inj_mask;
            idx_q <= grant_rd ? ar_idx : aw_idx;
            oor_q <= grant_rd ? ar_oor : aw_oor;
        end
        if (grant_wr) begin
            wdata_q <= mem_axi_wdata;
            wstrb_q <= mem_axi_wstrb;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_wr         <= 1'b0;
            lat_q         <= '0;
            scrub_q       <= 1'b0;
            mem_axi_rdata <= '0;
            mem_axi_rresp <= AXI_RESP_OKAY;
            mem_axi_bresp <= AXI_RESP_OKAY;
            err_corr      <= 1'b0;
            err_uncorr    <= 1'b0;
            corr_cnt      <= '0;
            uncorr_cnt    <= '0;
        end else begin
            state      <= state_n;
            lat_q      <= state == RD_PIPE ? lat_q + 1'b1 : '0;
            scrub_q    <= SCRUB && rd_done && !oor_q && dec_status == CORR;
            err_corr   <= corr_ev;
            err_uncorr <= uncorr_ev;
            corr_cnt   <= cnt_clr ? '0 : corr_cnt + CNT_W'(corr_ev && !(&corr_cnt));
            uncorr_cnt <= cnt_clr ? '0 : uncorr_cnt + CNT_W'(uncorr_ev && !(&uncorr_cnt));
            if (conflict) rr_wr <= grant_rd;
            if (grant_wr) mem_axi_bresp <= aw_oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            if (state == RMW_RD) mem_axi_bresp <= bad ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            if (rd_done) begin
                mem_axi_rdata <= oor_q ? '0 : dec_data;
                mem_axi_rresp <= bad ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
        end
    end
endmodule

// File: tb/tb_axi_ecc_memory.sv
// tb_axi_ecc_memory: directed checks of axi_ecc_memory with hand-computed expectations
module tb_axi_ecc_memory;
    localparam int DW = 32;
    localparam int CW = 39;
    localparam int CNT_W = 16;

    logic clk = 1'b0, reset = 1'b1;
    logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, cnt_clr = 0;
    logic awready, wready, bvalid, arready, rvalid, err_corr, err_uncorr;
    logic [31:0] awaddr = 0, araddr = 0;
    logic [DW-1:0] wdata = 0, rdata;
    logic [DW/8-1:0] wstrb = 0;
    logic [1:0] bresp, rresp;
    logic [CW-1:0] inj_mask = '0;
    logic [CNT_W-1:0] corr_cnt, uncorr_cnt;
    int n_vec = 0, n_err = 0;

    axi_ecc_memory #(.DATA_W(DW), .DEPTH(32768), .RD_LAT(1), .CNT_W(CNT_W), .SCRUB(1)) dut (
        .clk(clk), .reset(reset),
        .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
        .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
        .mem_axi_bvalid(bvalid), .mem_axi_bready(bready), .mem_axi_bresp(bresp),
        .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr),
        .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata), .mem_axi_rresp(rresp),
        .inj_mask(inj_mask), .err_corr(err_corr), .err_uncorr(err_uncorr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] mask(input int a, input int b);
        logic [CW-1:0] m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        return m;
    endfunction

    task automatic rd(input logic [31:0] a, input int hold, output logic [31:0] d,
                      output logic [1:0] r, output int lat, output int pc, output int pu);
        int t = 0;
        pc = 0; pu = 0; lat = 0;
        araddr = a; arvalid = 1; #1;
        while (!arready && t < 20) begin @(negedge clk); t++; end
        check("arready", arready, 1);
        @(posedge clk); #1 arvalid = 0;
        do begin
            @(negedge clk); lat++; pc += int'(err_corr); pu += int'(err_uncorr);
        end while (!rvalid && lat < 20);
        check("rvalid", rvalid, 1);
        d = rdata; r = rresp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); pc += int'(err_corr); pu += int'(err_uncorr);
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", rdata, d);
            check("rresp_hold", rresp, r);
        end
        rready = 1; @(posedge clk); #1 rready = 0;
        @(negedge clk); pc += int'(err_corr); pu += int'(err_uncorr);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] r, output int lat, output int pc, output int pu);
        int t = 0;
        pc = 0; pu = 0; lat = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; #1;
        while (!awready && t < 20) begin @(negedge clk); t++; end
        check("awready", awready, 1);
        check("wready", wready, 1);
        @(posedge clk); #1 awvalid = 0; wvalid = 0;
        do begin
            @(negedge clk); lat++; pc += int'(err_corr); pu += int'(err_uncorr);
        end while (!bvalid && lat < 20);
        check("bvalid", bvalid, 1);
        r = bresp;
        bready = 1; @(posedge clk); #1 bready = 0;
        @(negedge clk); pc += int'(err_corr); pu += int'(err_uncorr);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0] r;
        logic [7:0] g [3];
        int lat, pc, pu, t;

        repeat (2) @(negedge clk);
        arvalid = 1; awvalid = 1; wvalid = 1; #1;
        check("rst_arready", arready, 0);
        check("rst_awready", awready, 0);
        check("rst_valids", {bvalid, rvalid, err_corr, err_uncorr}, 0);
        check("rst_resp_data", {bresp, rresp, rdata}, 0);
        check("rst_cnts", {corr_cnt, uncorr_cnt}, 0);
        arvalid = 0; awvalid = 0; wvalid = 0;
        @(negedge clk); reset = 0; @(negedge clk);

        wr(32'h100, 32'hDEADBEEF, 4'hF, r, lat, pc, pu);
        check("full_bresp", r, 2'b00);
        check("full_lat", lat, 1);
        rd(32'h100, 0, d, r, lat, pc, pu);
        check("clean_rdata", d, 32'hDEADBEEF);
        check("clean_rresp", r, 2'b00);
        check("clean_lat", lat, 2);
        check("clean_pulses", {pc[7:0], pu[7:0]}, 0);

        inj_mask = mask(5, -1);
        rd(32'h100, 0, d, r, lat, pc, pu);
        check("sbe_rdata", d, 32'hDEADBEEF);
        check("sbe_rresp", r, 2'b00);
        check("sbe_pulse", {pc[7:0], pu[7:0]}, 16'h0100);
        check("sbe_cnt", corr_cnt, 1);
        inj_mask = '0;
        rd(32'h100, 0, d, r, lat, pc, pu);
        check("scrubbed_rdata", d, 32'hDEADBEEF);
        check("scrubbed_pulse", pc, 0);
        check("scrubbed_cnt", corr_cnt, 1);

        inj_mask = mask(33, -1);
        rd(32'h100, 0, d, r, lat, pc, pu);
        check("chkbit_rdata", d, 32'hDEADBEEF);
        check("chkbit_rresp", r, 2'b00);
        check("chkbit_cnt", corr_cnt, 2);

        inj_mask = mask(5, 38);
        rd(32'h100, 0, d, r, lat, pc, pu);
        check("dbe_rdata", d, 32'hDEADBECF);
        check("dbe_rresp", r, 2'b10);
        check("dbe_pulse", {pc[7:0], pu[7:0]}, 16'h0001);
        check("dbe_cnts", {corr_cnt, uncorr_cnt}, {16'd2, 16'd1});

        inj_mask = '0;
        wr(32'h100, 32'h000000AA, 4'h1, r, lat, pc, pu);
        check("rmw_bresp", r, 2'b00);
        check("rmw_lat", lat, 2);
        rd(32'h100, 0, d, r, lat, pc, pu);
        check("rmw_rdata", d, 32'hDEADBEAA);

        inj_mask = mask(5, 38);
        wr(32'h100, 32'h00000055, 4'h1, r, lat, pc, pu);
        check("rmw_dbe_bresp", r, 2'b10);
        check("rmw_dbe_pulse", {pc[7:0], pu[7:0]}, 16'h0001);
        inj_mask = '0;
        rd(32'h100, 0, d, r, lat, pc, pu);
        check("rmw_dbe_kept", d, 32'hDEADBEAA);

        inj_mask = mask(0, -1);
        wr(32'h100, 32'h00001100, 4'h2, r, lat, pc, pu);
        check("rmw_sbe_bresp", r, 2'b00);
        check("rmw_sbe_pulse", {pc[7:0], pu[7:0]}, 16'h0100);
        inj_mask = '0;
        rd(32'h100, 0, d, r, lat, pc, pu);
        check("rmw_sbe_rdata", d, 32'hDEAD11AA);
        check("rmw_cnts", {corr_cnt, uncorr_cnt}, {16'd3, 16'd2});

        wr(32'h0, 32'h12345678, 4'hF, r, lat, pc, pu);
        wr(32'h1000_0000, 32'hFFFFFFFF, 4'hF, r, lat, pc, pu);
        check("oor_wr_bresp", r, 2'b10);
        check("oor_wr_lat", lat, 1);
        inj_mask = mask(5, 38);
        wr(32'h1000_0000, 32'hFFFFFFFF, 4'h1, r, lat, pc, pu);
        check("oor_rmw_bresp", r, 2'b10);
        check("oor_rmw_lat", lat, 2);
        check("oor_rmw_pulse", {pc[7:0], pu[7:0]}, 0);
        inj_mask = mask(5, -1);
        rd(32'h1000_0000, 0, d, r, lat, pc, pu);
        check("oor_rd_rresp", r, 2'b10);
        check("oor_rd_rdata", d, 0);
        check("oor_rd_lat", lat, 2);
        check("oor_rd_pulse", {pc[7:0], pu[7:0]}, 0);
        check("oor_cnts", {corr_cnt, uncorr_cnt}, {16'd3, 16'd2});
        inj_mask = '0;
        rd(32'h0, 0, d, r, lat, pc, pu);
        check("oor_no_alias", d, 32'h12345678);

        wr(32'h100, 32'h0, 4'h0, r, lat, pc, pu);
        check("nostrb_bresp", r, 2'b00);
        check("nostrb_lat", lat, 1);
        rd(32'h103, 5, d, r, lat, pc, pu);
        check("lowbits_rdata", d, 32'hDEAD11AA);

        awaddr = 32'h0; wdata = 32'hFF; wstrb = 4'h1; awvalid = 1; wvalid = 1; #1;
        check("midrmw_awready", awready, 1);
        @(posedge clk); #1 awvalid = 0; wvalid = 0;
        #1 reset = 1; #1;
        check("async_cnts", {corr_cnt, uncorr_cnt}, 0);
        check("async_outs", {bvalid, rvalid, awready, arready, bresp, rresp, rdata}, 0);
        @(negedge clk); reset = 0; @(negedge clk);
        rd(32'h0, 0, d, r, lat, pc, pu);
        check("midrmw_lost", d, 32'h12345678);

        for (int k = 0; k < 3; k++) begin
            araddr = 32'h100; awaddr = 32'h0; wdata = 32'h12345678; wstrb = 4'hF;
            arvalid = 1; awvalid = 1; wvalid = 1; #1;
            g[k] = arready ? "R" : awready ? "W" : "-";
            @(posedge clk); #1 arvalid = 0; awvalid = 0; wvalid = 0;
            t = 0;
            while (!(rvalid || bvalid) && t < 20) begin @(negedge clk); t++; end
            check("grant_resp", rvalid | bvalid, 1);
            rready = 1; bready = 1; @(posedge clk); #1 rready = 0; bready = 0;
            @(negedge clk);
        end
        check("grant0", g[0], "R");
        check("grant1", g[1], "W");
        check("grant2", g[2], "R");

        inj_mask = mask(5, -1);
        rd(32'h100, 0, d, r, lat, pc, pu);
        check("pre_clr_cnt", corr_cnt, 1);
        cnt_clr = 1;
        rd(32'h100, 0, d, r, lat, pc, pu);
        check("clr_pulse", pc, 1);
        check("clr_cnt", corr_cnt, 0);
        cnt_clr = 0; inj_mask = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end
endmodule

// File: doc/axi_ecc_memory.md
Name: axi_ecc_memory

Overview:
Parametrised AXI4-lite memory slave that stores each word as a SECDED codeword (data plus check bits) and generalises the simulation memory used by the picorv32_axi ECC bench into synthesizable RTL. It supports configurable width, depth and read latency, plus a runtime error-injection mask. Byte-strobe writes use read-modify-write. Corrected and uncorrectable events are reported per transfer and counted. It sits directly on the core's mem_axi_* bus as the instruction/data RAM.

Parameters:
DATA_W, 32, data width; power of two, 16..64
DEPTH, 32768, number of words; memory byte range is 0..DEPTH*DATA_W/8-1
RD_LAT, 1, cycles from array read to rvalid; 1..4
CNT_W, 16, width of the error counters
SCRUB, 1, write back the corrected codeword after a correctable read

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
mem_axi_awvalid/awready  in/out  1  write-address handshake
mem_axi_awaddr  in  32  byte write address
mem_axi_wvalid/wready  in/out  1  write-data handshake
mem_axi_wdata  in  DATA_W  write data
mem_axi_wstrb  in  DATA_W/8  byte strobes
mem_axi_bvalid/bready  out/in  1  write response
mem_axi_bresp  out  2  00 OKAY, 10 SLVERR
mem_axi_arvalid/arready  in/out  1  read-address handshake
mem_axi_araddr  in  32  byte read address
mem_axi_rvalid/rready  out/in  1  read response
mem_axi_rdata  out  DATA_W  read data
mem_axi_rresp  out  2  00 OKAY, 10 SLVERR
inj_mask  in  DATA_W+CHK_W  XOR mask applied to the codeword as read from the array
err_corr  out  1  one-cycle pulse on a corrected single-bit error
err_uncorr  out  1  one-cycle pulse on a detected double-bit error
corr_cnt  out  CNT_W  saturating count of corrected errors
uncorr_cnt  out  CNT_W  saturating count of uncorrectable errors
cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- CHK_W = log2(DATA_W)+2 (Hamming bits plus overall parity), giving 7 check bits for 32-bit data. Clock is clk; reset is asynchronous and active-high.
- On reset, all ready/valid outputs are 0, bresp/rresp are 00, rdata is 0, both pulses are 0, both counters are 0, and the FSM is in IDLE. Array contents are not reset.
- FSM states: IDLE, RD_PIPE, RD_RESP, RMW_RD, WR_RESP.
- IDLE arbitration: a write is eligible only when awvalid and wvalid are both high. If both a read and a write are eligible, grant round-robin; the first conflict after reset goes to the read.
- Read acceptance: arready pulses for 1 cycle and the array is read that cycle. After RD_LAT cycles in RD_PIPE, enter RD_RESP with rvalid=1.
- rvalid, rdata and rresp stay stable until rready. The FSM returns to IDLE in the cycle after the handshake. Minimum read-to-read spacing is RD_LAT+2 cycles.
- Decode is performed on stored_codeword XOR inj_mask, with inj_mask sampled in the array-read cycle:
  - No error: OKAY.
  - Single-bit error (including a check-bit-only error): corrected data, OKAY, err_corr pulses, corr_cnt increments.
  - Double-bit error: raw data bits, SLVERR, err_uncorr pulses, uncorr_cnt increments.
- Pulses and counter updates occur in the cycle rvalid first rises.
- SCRUB=1: on a correctable read, the re-encoded corrected word is written to the array in the first RD_RESP cycle. inj_mask is never stored.
- Write with all strobes set: awready and wready pulse together, the encoded word is written that cycle, and bvalid=1 with OKAY the next cycle.
- Partial-strobe write: handshake, then RMW_RD reads and decodes the old word (with inj_mask), merges the strobed bytes, re-encodes and writes. bvalid follows one cycle later.
  - If the old word is uncorrectable, nothing is written, bresp=SLVERR and err_uncorr pulses.
  - If the old word is correctable, it is corrected before the merge and err_corr pulses.
- Zero strobes: no array write; bresp=OKAY.
- bvalid is held until bready; the FSM then returns to IDLE.
- Out-of-range address (>= DEPTH*DATA_W/8): no array access, SLVERR, no error pulses or counts. Latency matches an in-range access.
- Address low bits below the word size are ignored.
- Counters saturate at all-ones. cnt_clr has priority over a same-cycle increment.
- Reset asserted mid-transaction aborts it immediately; any write not yet committed to the array is lost.

Decomposition:
- Package axi_ecc_pkg:
  - AXI_RESP_OKAY and AXI_RESP_SLVERR constants
  - FSM state enum
  - chk_w(DATA_W) constant function
  - ecc_status typedef {NONE, CORR, UNCORR}
- Sub-module ecc_secded_codec, purely combinational:
  - encode: data to codeword
  - decode: codeword to {corrected data, status, syndrome}
  - instantiated twice: once for the write path, once for the read/RMW path

Test Plan:
- Write 0xDEADBEEF to 0x100 with wstrb=1111, then read 0x100 with inj_mask=0 -> bresp=00; rdata=0xDEADBEEF, rresp=00, no pulses, rvalid exactly RD_LAT+1 cycles after the arready pulse.
- Read 0x100 with inj_mask bit 5 set -> rdata=0xDEADBEEF, rresp=00, err_corr one pulse, corr_cnt=1. A following clean read (SCRUB=1, mask=0) -> no pulse, corr_cnt stays 1.
- Read 0x100 with inj_mask bits 5 and 38 set -> rresp=10, err_uncorr one pulse, uncorr_cnt=1, corr_cnt unchanged.
- Write 0x000000AA with wstrb=0001 to 0x100 and mask 0 -> bresp=00; a subsequent read returns 0xDEADBEAA. Repeat with a 2-bit mask during RMW -> bresp=10 and the word is still 0xDEADBEAA.
- Access 0x1000_0000 for read and write -> both SLVERR, no array change, counters unchanged. Hold rready=0 for 5 cycles -> rvalid and rdata stable.
- Drive AR and AW+W simultaneously three times -> grant order is read, write, read. Assert reset mid-RMW -> all outputs return to reset values asynchronously; cnt_clr while an increment is pending -> counter reads 0.
